// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit blocks.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

   localparam int UART_DATA_BITS         = 8;
   localparam int UART_CLKS_PER_BIT_DFLT = 48;

   // [8] = error flag, [7:0] = received byte
   typedef logic [8:0] uart_rx_word_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
module uart_sync2 (
   input  logic Clk,
   input  logic Rstn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: start/8 data/optional parity/stop, mid-bit sampling by cycle count.
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DFLT,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic          Clk,
   input  logic          Rstn,
   input  logic          SerDataIn,
   output uart_rx_word_t PalDataOut,
   output logic          PalDataOutValid
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_e                 state, stateNxt;
   logic                      rxS, rxPrev;
   logic [CNT_W-1:0]          bitCnt;
   logic [2:0]                idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      parErr, frmErr, stopDone;
   logic                      bitDone;

   uart_sync2 uSync (
      .Clk  (Clk),
      .Rstn (Rstn),
      .d    (SerDataIn),
      .q    (rxS)
   );

   // START samples half a bit in; every later sample is one full bit after the previous.
   always_comb begin
      bitDone = 1'b0;
      if (state == START)     bitDone = (bitCnt == MID_CNT);
      else if (state != IDLE) bitDone = (bitCnt == FULL_CNT);
   end

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) state <= IDLE;
      else       state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (rxPrev && !rxS) stateNxt = START;
         START:   if (bitDone) stateNxt = rxS ? IDLE : DATA;
         DATA:    if (bitDone && idx == 3'd7) stateNxt = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (bitDone) stateNxt = STOP;
         // Leave at the stop mid-point so an immediately following start edge is seen.
         STOP:    if (bitDone) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         rxPrev <= 1'b1;
         bitCnt <= '0;
         idx    <= '0;
         shreg  <= '0;
         parErr <= 1'b0;
         frmErr <= 1'b0;
      end else begin
         rxPrev <= rxS;

         if (stateNxt != state || bitDone) bitCnt <= '0;
         else if (state != IDLE)           bitCnt <= bitCnt + 1'b1;

         if (state == START) begin
            idx    <= '0;
            parErr <= 1'b0;
         end

         if (state == DATA && bitDone) begin
            shreg[idx] <= rxS;
            idx        <= idx + 3'd1;
         end

         if (state == PARITY && bitDone)
            parErr <= (^shreg) ^ rxS ^ 1'(PARITY_ODD);

         if (state == STOP && bitDone)
            frmErr <= ~rxS;
      end
   end

   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         stopDone        <= 1'b0;
         PalDataOut      <= '0;
         PalDataOutValid <= 1'b0;
      end else begin
         stopDone        <= (state == STOP) && bitDone;
         PalDataOutValid <= stopDone;
         if (stopDone)
            PalDataOut <= {parErr | frmErr, shreg};
      end
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: vector table plus hand-built corner sequences.
module tb_uart_rx_deser;
   import uart_pkg::*;

   localparam int CPB = 48;

   logic          Clk = 1'b0;
   logic          Rstn = 1'b0;
   logic          SerDataIn = 1'b1;
   uart_rx_word_t PalDataOut;
   logic          PalDataOutValid;

   int nCmp = 0;
   int nBad = 0;
   uart_rx_word_t got[$];

   always #5 Clk = ~Clk;

   uart_rx_deser #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut (
      .Clk             (Clk),
      .Rstn            (Rstn),
      .SerDataIn       (SerDataIn),
      .PalDataOut      (PalDataOut),
      .PalDataOutValid (PalDataOutValid)
   );

   always @(negedge Clk)
      if (PalDataOutValid) got.push_back(PalDataOut);

   typedef struct {
      logic [7:0]    d;
      logic          pb;
      logic          sb;
      int            per;
      uart_rx_word_t exp;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      nCmp++;
      if (act != exp) begin
         nBad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic sendFrame(input logic [7:0] d, input logic pb, input logic sb,
                            input int per, input int nBits = 11);
      logic [10:0] f;
      f = {sb, pb, d, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         SerDataIn = f[i];
         idle(per);
      end
   endtask

   vec_t vecs[6];
   int   p0;

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 48, 9'h0A5};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 48, 9'h13C};
      vecs[2] = '{8'h00, 1'b0, 1'b1, 48, 9'h000};
      vecs[3] = '{8'h80, 1'b1, 1'b1, 48, 9'h080};
      vecs[4] = '{8'h80, 1'b0, 1'b1, 46, 9'h180};
      vecs[5] = '{8'hC3, 1'b0, 1'b1, 50, 9'h0C3};

      idle(3);
      check("reset_data", int'(PalDataOut), 0);
      check("reset_valid", int'(PalDataOutValid), 0);
      Rstn = 1'b1;
      idle(2 * CPB);

      foreach (vecs[i]) begin
         p0 = got.size();
         sendFrame(vecs[i].d, vecs[i].pb, vecs[i].sb, vecs[i].per);
         SerDataIn = 1'b1;
         idle(CPB);
         check($sformatf("vec%0d_pulses", i), got.size() - p0, 1);
         if (got.size() > p0) check($sformatf("vec%0d_data", i), int'(got[$]), int'(vecs[i].exp));
      end

      // Framing error, then a break; a one-bit high gap gives the break its own falling edge.
      p0 = got.size();
      sendFrame(8'hFF, 1'b0, 1'b0, CPB);
      SerDataIn = 1'b1;
      idle(CPB);
      check("stop0_pulses", got.size() - p0, 1);
      if (got.size() > p0) check("stop0_data", int'(got[$]), 9'h1FF);
      p0 = got.size();
      SerDataIn = 1'b0;
      idle(20 * CPB);
      check("break_pulses", got.size() - p0, 1);
      if (got.size() > p0) check("break_data", int'(got[$]), 9'h100);
      SerDataIn = 1'b1;
      idle(3 * CPB);
      check("break_after", got.size() - p0, 1);

      // Short low glitch must not start a frame.
      p0 = got.size();
      SerDataIn = 1'b0;
      idle(20);
      SerDataIn = 1'b1;
      idle(3 * CPB);
      check("glitch_pulses", got.size() - p0, 0);
      sendFrame(8'h5A, 1'b0, 1'b1, CPB);
      SerDataIn = 1'b1;
      idle(CPB);
      check("post_glitch_pulses", got.size() - p0, 1);
      if (got.size() > p0) check("post_glitch_data", int'(got[$]), 9'h05A);

      // Back-to-back frames, fast then slow bit periods.
      for (int per = 46; per <= 50; per += 4) begin
         p0 = got.size();
         sendFrame(8'h01, 1'b1, 1'b1, per);
         sendFrame(8'h80, 1'b1, 1'b1, per);
         sendFrame(8'h55, 1'b0, 1'b1, per);
         SerDataIn = 1'b1;
         idle(CPB);
         check($sformatf("b2b%0d_pulses", per), got.size() - p0, 3);
         if (got.size() == p0 + 3) begin
            check($sformatf("b2b%0d_w0", per), int'(got[p0]),     9'h001);
            check($sformatf("b2b%0d_w1", per), int'(got[p0 + 1]), 9'h080);
            check($sformatf("b2b%0d_w2", per), int'(got[p0 + 2]), 9'h055);
         end
      end

      // Reset in the middle of data bit 4.
      p0 = got.size();
      sendFrame(8'hC3, 1'b0, 1'b1, CPB, 5);
      idle(CPB / 2);
      Rstn = 1'b0;
      #1;
      check("midrst_data", int'(PalDataOut), 0);
      check("midrst_valid", int'(PalDataOutValid), 0);
      idle(3);
      SerDataIn = 1'b1;
      idle(2);
      Rstn = 1'b1;
      idle(3 * CPB);
      check("midrst_pulses", got.size() - p0, 0);
      sendFrame(8'h99, 1'b0, 1'b1, CPB);
      SerDataIn = 1'b1;
      idle(CPB);
      check("post_rst_pulses", got.size() - p0, 1);
      if (got.size() > p0) check("post_rst_data", int'(got[$]), 9'h099);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive half of the UART DUT: deserialises `SerDataIn` into `PalDataOut`, qualified by `PalDataOutValid`.
- Frame: 1 start bit, 8 data bits (LSB first), optional parity bit, 1 stop bit.
- Bit timing is a clock-cycle count: 48 cycles per bit at 12.288 MHz, giving 256000 bps.
- Sits between the serial line pin and the parallel consumer; the transmit path is a separate block.

Parameters:
- `CLKS_PER_BIT`, 48, clock cycles per bit period; legal range 8..4095.
- `PARITY_EN`, 1, 1 = parity bit present between data and stop.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; ignored when `PARITY_EN` = 0.

Ports:
- `Clk` in 1: single clock, all logic on the rising edge.
- `Rstn` in 1: reset, asynchronous assert, active-low; deassertion synchronised by the integrator.
- `SerDataIn` in 1: asynchronous serial line, idles high.
- `PalDataOut` out 9: [7:0] received byte; [8] error flag, set on parity error or stop-bit = 0.
- `PalDataOutValid` out 1: one-cycle pulse; `PalDataOut` is valid in that cycle.

Behaviour:
- Reset (`Rstn` = 0, asynchronous):
  - State = IDLE, counters = 0.
  - Synchroniser flops = 1 (idle line).
  - `PalDataOut` = 9'h000, `PalDataOutValid` = 0.
- Input conditioning: 2-flop synchroniser on `SerDataIn`, plus a registered copy of the synchroniser output for edge detection. All sampling uses the synchronised value (`rx_s`).
- Counters:
  - `bit_cnt` width = `$clog2(CLKS_PER_BIT)`; `idx` 3 bits.
  - `bit_cnt` reloads to 0 on every state change.
- IDLE: on a falling edge of `rx_s` (previous 1, current 0), go to START. A line held low never retriggers; a new 1 -> 0 edge is required.
- START:
  - Count to `CLKS_PER_BIT/2 - 1` (mid start bit), then sample.
  - Sample = 1: glitch; return to IDLE with no output.
  - Sample = 0: go to DATA with `idx` = 0.
- DATA:
  - Sample when `bit_cnt` = `CLKS_PER_BIT - 1` (mid-bit); shift into `shreg[idx]` (LSB first).
  - After `idx` = 7: go to PARITY if `PARITY_EN`, else to STOP.
- PARITY:
  - Sample at `CLKS_PER_BIT - 1`.
  - `par_err` = (^`shreg`) ^ sample ^ `PARITY_ODD`; the result must be 0 for a correct frame.
  - Go to STOP.
- STOP:
  - Sample at `CLKS_PER_BIT - 1`.
  - `frm_err` = (sample == 0).
  - In the next cycle: register `PalDataOut` = {`par_err` | `frm_err`, `shreg`} and pulse `PalDataOutValid` = 1 for exactly one cycle.
  - Return to IDLE at the stop-bit sample point, not at the stop-bit end, so a start edge arriving half a bit later is caught.
- Latency: `PalDataOutValid` rises 2 cycles after the stop-bit mid sample.
  - 1 cycle for the stop sample register, 1 cycle for the output register.
  - Line-to-sample delay adds 2 cycles through the synchroniser.
- `PalDataOut` holds its last value between pulses; it is never cleared except by reset.
- Break (line held low for a whole frame): one output with data 8'h00 and error flag = 1. No further output until the line returns high and falls again.
- Back-to-back frames (stop immediately followed by start) must all be received; no dead time is required.
- Reset mid-frame: returns immediately to IDLE with outputs zeroed. A partial frame never produces a valid pulse. Reception resumes on the next falling edge after `Rstn` goes high.
- Baud tolerance: frames at ±3% of nominal bit rate must be received error-free at `CLKS_PER_BIT` = 48.
- No backpressure: the consumer must take the data in the valid cycle; overrun is not detectable.

Decomposition:
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e`.
  - Localparam `UART_DATA_BITS` = 8, `UART_CLKS_PER_BIT_DFLT` = 48.
  - `typedef logic [8:0] uart_rx_word_t`.
- One sub-module: `uart_sync2`, a 2-flop synchroniser with asynchronous active-low reset to 1. It is reusable by the transmit block's permit input.
- The FSM, counters and shift register stay in `uart_rx_deser`.

Test Plan:
- Even parity, byte 8'hA5, parity bit 0, stop 1 at 48 cycles/bit -> single `PalDataOutValid` pulse, `PalDataOut` = 9'h0A5.
- Byte 8'h3C sent with a wrong parity bit (1) -> `PalDataOut` = 9'h13C, one pulse.
- Byte 8'hFF with stop bit driven 0 -> `PalDataOut` = 9'h1FF.
  - Then hold the line low for 20 bit times -> exactly one more pulse, 9'h100; none thereafter until the line goes high and falls again.
- Low glitch of 20 cycles on an idle line -> no pulse, FSM back in IDLE. Then a valid 8'h5A -> 9'h05A.
- Three back-to-back frames 8'h01, 8'h80, 8'h55 with zero idle gap, bit period 46 cycles then 50 cycles -> three pulses, values 9'h001, 9'h080, 9'h055.
- `Rstn` asserted during data bit 4 of frame 8'hC3 -> outputs immediately 0 with no pulse. After release, frame 8'h99 -> 9'h099.
